// File: rtl/serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b - bin, one 4-bit slice per clock, LSB nibble first.
// Operands are captured on start; the borrow is carried between slices in a register.
//
// state | meaning
// IDLE  | waiting for start; outputs hold the last completed result
// RUN   | one nibble slice processed per clock, borrow registered between slices
// DONE  | one-cycle done pulse, result registers just updated
module serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_nxt;
  logic             borrow_r;
  logic [IW-1:0]    idx;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [4:0]       slice;
  logic             last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  assign last = (idx == LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slice mux and working-result update, unrolled over the nibble positions.
  always_comb begin
    nib_a    = '0;
    nib_b    = '0;
    work_nxt = work;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        nib_a = a_r[4*i +: 4];
        nib_b = b_r[4*i +: 4];
      end
    end
    slice = {1'b0, nib_a} - {1'b0, nib_b} - {4'b0000, borrow_r};
    for (int i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        work_nxt[4*i +: 4] = slice[3:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r        <= '0;
      b_r        <= '0;
      work       <= '0;
      borrow_r   <= 1'b0;
      idx        <= '0;
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r      <= a;
            b_r      <= b;
            borrow_r <= bin;
            idx      <= '0;
            work     <= '0;
          end
        end
        RUN: begin
          work     <= work_nxt;
          borrow_r <= slice[4];
          idx      <= idx + IW'(1);
          if (last) begin
            diff       <= work_nxt;
            borrow_out <= slice[4];
            overflow   <= (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                          (work_nxt[WIDTH-1] != a_r[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: WIDTH=16 and WIDTH=4 instances, an arithmetic reference
// model compared every cycle, plus literal expectations for the directed cases.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] d;
    logic        bo;
    logic        ov;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, bin16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        busy16, done16, bo16, ov16;
  logic [15:0] diff16;

  logic        start4 = 1'b0, bin4 = 1'b0;
  logic [3:0]  a4 = '0, b4 = '0;
  logic        busy4, done4, bo4, ov4;
  logic [3:0]  diff4;

  int errors = 0;
  int checks = 0;

  serial_subtractor #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow_out(bo16), .overflow(ov16)
  );

  serial_subtractor #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .borrow_out(bo4), .overflow(ov4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Plain integer arithmetic: unsigned borrow and signed range test.
  function automatic res_t ref_sub(input int w, input int a, input int b, input int bi);
    res_t r;
    int   full, sa, sb, sd, half;
    half = 1 << (w - 1);
    full = a - b - bi;
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    sd   = sa - sb - bi;
    r.d  = 16'(full & ((1 << w) - 1));
    r.bo = (full < 0);
    r.ov = (sd < -half) || (sd >= half);
    return r;
  endfunction

  int   m16_cnt, m4_cnt;
  logic m16_done, m4_done;
  res_t m16_res, m4_res, p16, p4;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m16_cnt <= 0; m16_done <= 1'b0; m16_res <= '0; p16 <= '0;
    end else if (m16_cnt > 0) begin
      m16_cnt <= m16_cnt - 1;
      if (m16_cnt == 1) begin
        m16_done <= 1'b1;
        m16_res  <= p16;
      end
    end else if (m16_done) begin
      m16_done <= 1'b0;
    end else if (start16) begin
      p16     <= ref_sub(16, int'(a16), int'(b16), int'(bin16));
      m16_cnt <= 4;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4_cnt <= 0; m4_done <= 1'b0; m4_res <= '0; p4 <= '0;
    end else if (m4_cnt > 0) begin
      m4_cnt <= m4_cnt - 1;
      if (m4_cnt == 1) begin
        m4_done <= 1'b1;
        m4_res  <= p4;
      end
    end else if (m4_done) begin
      m4_done <= 1'b0;
    end else if (start4) begin
      p4     <= ref_sub(4, int'(a4), int'(b4), int'(bin4));
      m4_cnt <= 1;
    end
  end

  always @(negedge clk) begin
    check("busy16", busy16, m16_cnt > 0);
    check("done16", done16, m16_done);
    check("diff16", diff16, m16_res.d);
    check("bo16", bo16, m16_res.bo);
    check("ov16", ov16, m16_res.ov);
    check("busy4", busy4, m4_cnt > 0);
    check("done4", done4, m4_done);
    check("diff4", diff4, m4_res.d[3:0]);
    check("bo4", bo4, m4_res.bo);
    check("ov4", ov4, m4_res.ov);
  end

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic bi,
                      input logic [15:0] ed, input logic ebo, input logic eov, input bit lit);
    int n_busy;
    bit got;
    @(negedge clk);
    a16 = a; b16 = b; bin16 = bi; start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    n_busy = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy16) n_busy++;
      if (done16) got = 1;
      else @(negedge clk);
    end
    check("op16_done_seen", got, 1);
    check("op16_busy_cycles", n_busy, 4);
    if (lit) begin
      check("op16_diff_lit", diff16, ed);
      check("op16_bo_lit", bo16, ebo);
      check("op16_ov_lit", ov16, eov);
    end
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic bi);
    int n_busy;
    bit got;
    @(negedge clk);
    a4 = a; b4 = b; bin4 = bi; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    n_busy = 0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (busy4) n_busy++;
      if (done4) got = 1;
      else @(negedge clk);
    end
    check("op4_done_seen", got, 1);
    check("op4_busy_cycles", n_busy, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int last_done, gap, n_done;
    bit seen;
    repeat (2) @(negedge clk);
    check("rst_busy", busy16, 0);
    check("rst_diff", diff16, 0);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done16 || busy16) seen = 1;
    end
    check("idle_no_activity", seen, 0);

    op16(16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1);

    // Asynchronous reset mid-cycle clears outputs at once.
    @(posedge clk); #2 rst_n = 1'b0; #1;
    check("async_rst_diff", diff16, 0);
    check("async_rst_busy", busy16, 0);
    check("async_rst_done", done16, 0);
    @(negedge clk); rst_n = 1'b1;

    op16(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1);
    op16(16'h0007, 16'h0009, 1'b1, 16'hFFFD, 1'b1, 1'b0, 1);
    op16(16'h0009, 16'h0009, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1);
    op16(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1);
    op16(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1);

    // Start pulses and operand changes during RUN are ignored.
    @(negedge clk);
    a16 = 16'h1234; b16 = 16'h0234; bin16 = 1'b0; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0; a16 = 16'hFFFF;
    @(negedge clk); start16 = 1'b1; b16 = 16'h1111; bin16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (done16) seen = 1;
      else @(negedge clk);
    end
    check("ignore_done_seen", seen, 1);
    check("ignore_diff_lit", diff16, 16'h1000);
    repeat (3) @(negedge clk);
    check("ignore_no_restart", busy16, 0);

    // start held high: done every 6 cycles.
    a16 = 16'h0050; b16 = 16'h0005; bin16 = 1'b0; start16 = 1'b1;
    last_done = -1; n_done = 0;
    for (int i = 0; i < 40 && n_done < 3; i++) begin
      @(negedge clk);
      if (done16) begin
        if (last_done >= 0) begin
          gap = i - last_done;
          check("b2b_period", gap, 6);
        end
        last_done = i;
        n_done++;
      end
    end
    check("b2b_done_count", n_done, 3);
    check("b2b_diff_lit", diff16, 16'h004B);
    start16 = 1'b0;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (!busy16 && !done16) seen = 1;
    end
    check("b2b_drain", seen, 1);

    // Reset during slice 2: abandoned, no done, diff cleared.
    @(negedge clk);
    a16 = 16'h4321; b16 = 16'h1111; start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; #1;
    check("abort_busy", busy16, 0);
    check("abort_diff", diff16, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done16) seen = 1;
    end
    check("abort_no_done", seen, 0);
    check("abort_diff_held", diff16, 0);

    for (int i = 0; i < 20; i++) op16(16'(i), 16'd7, 1'b0, 16'h0, 1'b0, 1'b0, 0);
    for (int i = 0; i < 20; i++) op4(4'(i), 4'd7, 1'b0);

    op4(4'h8, 4'h1, 1'b0);
    check("w4_ov_lit", {28'b0, diff4, bo4, ov4} >> 0, {28'b0, 4'h7, 1'b0, 1'b1});
    op4(4'h9, 4'h9, 1'b1);
    check("w4_wrap_lit", {diff4, bo4, ov4}, {4'hF, 1'b1, 1'b0});

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
